alu32_seq: RTL

- Sequential 32-bit ALU execute stage, directly downstream of the ALU control decoder.
- Consumes the decoder's 3-bit select code, `shift` and `sltu` qualifiers together with register operands, and produces a registered result with a start/done handshake.
- Logic/arithmetic ops complete in one cycle. Shifts are iterative, one bit per cycle, to save area in the datapath.

---
 rtl/alu32_seq_if.sv | 49 ++++
 rtl/alu32_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu32_seq_if.sv
// alu32_seq_if: request/result bundle between the ALU control stage and alu32_seq.
// master drives the request side; slave is the execute stage.
interface alu32_seq_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [2:0]         select_bits_ALU;
  logic               shift;
  logic               sltu;
  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   operand_b;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               overflow;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output select_bits_ALU,
    output shift,
    output sltu,
    output operand_a,
    output operand_b,
    output shamt,
    input  result,
    input  zero,
    input  overflow,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  select_bits_ALU,
    input  shift,
    input  sltu,
    input  operand_a,
    input  operand_b,
    input  shamt,
    output result,
    output zero,
    output overflow,
    output busy,
    output done
  );
endinterface

// File: rtl/alu32_seq.sv
// alu32_seq: ALU execute stage, 1-cycle logic/arith ops, shifts 1 bit/cycle.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts (no RUN state).
module alu32_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic        clk,
  input logic        rst_n,
  alu32_seq_if.slave bus
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_srl;
  logic             is_sll;

  assign a      = bus.operand_a;
  assign b      = bus.operand_b;
  assign is_srl = bus.select_bits_ALU == OP_SRL;
  assign is_sll = bus.shift && !is_srl;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic             lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = bus.sltu ? (a < b)
                         : ($signed(a) < $signed(b));

`ifdef ALU_BARREL_SHIFT_EN
  assign shl = b << bus.shamt;
  assign shr = b >> bus.shamt;
`else
  // The 1-cycle path only sees shifts with shamt == 0.
  assign shl = b;
  assign shr = b;
`endif

  logic [WIDTH-1:0] res_c;
  logic             ov_c;

  always_comb begin
    res_c = '0;
    ov_c  = 1'b0;
    unique case (1'b1)
      is_sll: res_c = shl;
      is_srl: res_c = shr;
      default: begin
        unique case (bus.select_bits_ALU)
          OP_AND: res_c = a & b;
          OP_OR:  res_c = a | b;
          OP_XOR: res_c = a ^ b;
          OP_NOR: res_c = ~(a | b);
          OP_ADD: begin
            res_c = sum;
            ov_c  = (a[WIDTH-1] == b[WIDTH-1])
                 && (sum[WIDTH-1] != a[WIDTH-1]);
          end
          OP_SUB: begin
            res_c = diff;
            ov_c  = (a[WIDTH-1] != b[WIDTH-1])
                 && (diff[WIDTH-1] != a[WIDTH-1]);
          end
          OP_SLT: res_c = {{(WIDTH-1){1'b0}}, lt};
          default: res_c = '0;
        endcase
      end
    endcase
  end

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ov_q;
  logic             done_q;

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ov_q;
  assign bus.done     = done_q;

`ifdef ALU_BARREL_SHIFT_EN

  assign bus.busy = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ov_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= bus.start;
      if (bus.start) begin
        result_q <= res_c;
        zero_q   <= res_c == '0;
        ov_q     <= ov_c;
      end
    end
  end

`else

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic               right;
  logic               busy_q;
  logic [WIDTH-1:0]   acc_sh;
  logic               go_run;

  assign bus.busy = busy_q;
  assign acc_sh   = right ? (acc >> 1) : (acc << 1);
  assign go_run   = (is_sll || is_srl)
                 && (bus.shamt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      right    <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ov_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (go_run) begin
              acc    <= b;
              cnt    <= bus.shamt;
              right  <= is_srl;
              busy_q <= 1'b1;
              state  <= RUN;
            end else begin
              result_q <= res_c;
              zero_q   <= res_c == '0;
              ov_q     <= ov_c;
              done_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_sh;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            result_q <= acc_sh;
            zero_q   <= acc_sh == '0;
            ov_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule
